// File: rtl/cu_pkg.sv
// cu_pkg: shared encodings for the datapath control unit.
package cu_pkg;
  typedef enum logic [2:0] {
    ST_RST, ST_FETCH0, ST_FETCH1, ST_FETCH2, ST_PCINC, ST_DECODE, ST_EXEC, ST_FAULT
  } state_t;
  localparam logic [4:0] ALU_OP_ADD = 5'd4;
  localparam logic [4:0] ALU_OP_PASSB = 5'd16;
  localparam logic [4:0] ALU_OP_PASSA = 5'd17;
  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;
  localparam logic [3:0] OPC_TST = 4'd8;
  localparam logic [3:0] OPC_CMN = 4'd11;
  function automatic logic is_test_op(input logic [3:0] opc);
    return opc >= OPC_TST && opc <= OPC_CMN;
  endfunction
endpackage

// File: rtl/cond_eval.sv
// cond_eval: ARM condition-field check against {N,Z,C,V}; NV never passes.
module cond_eval
  import cu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;
  always_comb begin
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/dp_control_unit.sv
// dp_control_unit: multi-cycle fetch/PC-increment/decode/execute sequencer for the ALU datapath.
module dp_control_unit
  import cu_pkg::*;
#(
  parameter int MOC_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic [31:0] IR,
  input  logic [3:0]  FLAGS,
  input  logic        MOC,
  output logic [4:0]  OP,
  output logic        S,
  output logic        ALU_OUT,
  output logic        LOAD,
  output logic        LOADPC,
  output logic        IR_CU,
  output logic        A_SEL,
  output logic        B_SEL,
  output logic        LOAD_MAR,
  output logic        LOAD_IR,
  output logic        MFA,
  output logic        RW,
  output logic        FAULT,
  output logic [2:0]  STATE
);
  localparam int CW = $clog2(MOC_TIMEOUT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic cond_pass, timeout, test_op, rd_pc, unused_ir;
  assign unused_ir = ^{IR[25], IR[19:16], IR[11:0]};
  cond_eval u_cond (.cond(IR[31:28]), .flags(FLAGS), .pass(cond_pass));
  assign timeout = cnt == CW'(MOC_TIMEOUT);
  assign test_op = is_test_op(IR[24:21]);
  assign rd_pc = IR[15:12] == 4'hF;
  assign STATE = state;
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) state <= ST_RST;
    else state <= state_n;
  end
  // Held at zero outside FETCH1, so every fetch wait starts counting from 0.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) cnt <= '0;
    else cnt <= (state == ST_FETCH1) ? cnt + 1'b1 : '0;
  end
  always_comb begin
    state_n = state;
    case (state)
      ST_RST:    state_n = ST_FETCH0;
      ST_FETCH0: state_n = ST_FETCH1;
      ST_FETCH1: state_n = MOC ? ST_FETCH2 : timeout ? ST_FAULT : ST_FETCH1;
      ST_FETCH2: state_n = ST_PCINC;
      ST_PCINC:  state_n = ST_DECODE;
      ST_DECODE: state_n = (cond_pass && IR[27:26] == 2'b00) ? ST_EXEC : ST_FETCH0;
      ST_EXEC:   state_n = ST_FETCH0;
      default:   state_n = ST_FAULT;
    endcase
  end
  always_comb begin
    OP = 5'd0;
    S = 1'b0;
    ALU_OUT = 1'b0;
    LOAD = 1'b0;
    LOADPC = 1'b0;
    IR_CU = 1'b1;
    A_SEL = 1'b0;
    B_SEL = 1'b0;
    LOAD_MAR = 1'b0;
    LOAD_IR = 1'b0;
    MFA = 1'b0;
    RW = 1'b1;
    FAULT = 1'b0;
    case (state)
      ST_FETCH0: begin
        A_SEL = 1'b1;
        OP = ALU_OP_PASSA;
        ALU_OUT = 1'b1;
        LOAD_MAR = 1'b1;
        IR_CU = 1'b0;
      end
      ST_FETCH1: MFA = 1'b1;
      ST_FETCH2: begin
        MFA = 1'b1;
        LOAD_IR = 1'b1;
      end
      ST_PCINC: begin
        A_SEL = 1'b1;
        B_SEL = 1'b1;
        OP = ALU_OP_ADD;
        ALU_OUT = 1'b1;
        LOADPC = 1'b1;
        IR_CU = 1'b0;
      end
      ST_EXEC: begin
        OP = {1'b0, IR[24:21]};
        S = IR[20];
        ALU_OUT = 1'b1;
        LOAD = !test_op && !rd_pc;
        LOADPC = !test_op && rd_pc;
      end
      ST_FAULT: FAULT = 1'b1;
      default: ;
    endcase
  end
endmodule
